// File: rtl/pc_pkg.sv
// Shared types and target computation for the program-counter unit.
// The target function works at 64 bits; callers truncate to their address width.
package pc_pkg;

  typedef enum logic {SEQ, SLOT} pc_state_e;

  localparam int RAS_DEPTH_DEF = 4;
  localparam int RAS_PTR_W     = $clog2(RAS_DEPTH_DEF);

  // Priority: jr, then jump/jal, then branch offset from pc+4.
  function automatic logic [63:0] calc_target(
    input logic        jr_sel,
    input logic        jump_sel,
    input logic [63:0] rs_val,
    input logic [63:0] pc_plus4,
    input logic [25:0] imm26
  );
    logic [63:0] br_off;
    br_off = {{46{imm26[15]}}, imm26[15:0], 2'b00};
    if (jr_sel) begin
      calc_target = rs_val & ~64'd3;
    end else if (jump_sel) begin
      calc_target = {pc_plus4[63:28], imm26, 2'b00};
    end else begin
      calc_target = pc_plus4 + br_off;
    end
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular storage that overwrites its oldest entry when
// full, with a count register and a sticky overflow flag.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;

  assign top_idx  = ptr_q - PTR_W'(1);
  assign top      = mem_q[top_idx];
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;

  always_comb begin
    mem_d      = mem_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      mem_d[ptr_q] = din;
      ptr_d        = ptr_q + PTR_W'(1);
      if (count_q == (PTR_W+1)'(DEPTH)) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + (PTR_W+1)'(1);
      end
    end else if (pop && !empty) begin
      ptr_d   = top_idx;
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter register with branch/jump/jr redirection, optional
// branch-delay-slot sequencing and a return-address stack cross-check on jr $ra.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'h0000_3000),
  parameter int                RAS_DEPTH  = 4,
  parameter int                DELAY_SLOT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              jump,
  input  logic              jal,
  input  logic              jr,
  input  logic              jr_ra,
  input  logic              beq,
  input  logic              bne,
  input  logic              bgt,
  input  logic              blt,
  input  logic              zero,
  input  logic              positive,
  input  logic              negative,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] link_addr,
  output logic              redirect,
  output logic              ras_mismatch,
  output logic              ras_overflow,
  output logic              ras_empty
);

  logic [ADDR_W-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0] target, rs_aligned, ras_top;
  pc_state_e         state_q, state_d;
  logic              ras_mismatch_q, ras_mismatch_d;
  logic              in_slot, jr_sel, jump_sel, taken, accept, push, pop;

  assign in_slot    = (DELAY_SLOT != 0) && (state_q == SLOT);
  assign jr_sel     = jr | jr_ra;
  assign jump_sel   = jump | jal;
  assign taken      = jr_sel | jump_sel | (beq & zero) | (bne & ~zero)
                    | (bgt & positive) | (blt & negative);
  assign accept     = ~stall & ~in_slot;
  assign push       = accept & jal & ~jr_sel;
  assign pop        = accept & jr_ra;
  assign rs_aligned = rs_val & ~ADDR_W'(3);

  assign pc           = pc_q;
  assign pc_plus4     = pc_q + ADDR_W'(4);
  assign link_addr    = (DELAY_SLOT != 0) ? pc_q + ADDR_W'(8) : pc_plus4;
  assign redirect     = taken & ~in_slot;
  assign ras_mismatch = ras_mismatch_q;
  assign target       = ADDR_W'(calc_target(jr_sel, jump_sel, 64'(rs_val),
                                            64'(pc_plus4), imm26));

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .din      (link_addr),
    .top      (ras_top),
    .empty    (ras_empty),
    .overflow (ras_overflow)
  );

  // In delay-slot mode a taken transfer parks its target until the slot retires.
  always_comb begin
    pc_d           = pc_q;
    pend_pc_d      = pend_pc_q;
    state_d        = state_q;
    ras_mismatch_d = pop & (ras_empty | (ras_top != rs_aligned));
    if (!stall) begin
      if (in_slot) begin
        pc_d    = pend_pc_q;
        state_d = SEQ;
      end else if (taken && (DELAY_SLOT != 0)) begin
        pend_pc_d = target;
        pc_d      = pc_plus4;
        state_d   = SLOT;
      end else if (taken) begin
        pc_d = target;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      pend_pc_q      <= '0;
      state_q        <= SEQ;
      ras_mismatch_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      pend_pc_q      <= pend_pc_d;
      state_q        <= state_d;
      ras_mismatch_q <= ras_mismatch_d;
    end
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit: one instance without and one with delay
// slots, both driven with the same inputs and each checked against its own model.
module tb_pc_seq_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] link;
    logic        redirect;
    logic        mism;
    logic        ovf;
    logic        empty;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, stall, jump, jal, jr, jr_ra, beq, bne, bgt, blt;
  logic        zero, positive, negative;
  logic [25:0] imm26;
  logic [31:0] rs_val;

  logic [31:0] pc_o [2];
  logic [31:0] pc_plus4_o [2];
  logic [31:0] link_o [2];
  logic        redirect_o [2];
  logic        mism_o [2];
  logic        ovf_o [2];
  logic        empty_o [2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] ras0[$];
  logic [31:0] ras1[$];
  logic [31:0] m_pc [2];
  logic [31:0] m_pend [2];
  bit          m_slot [2];
  bit          m_mism [2];
  bit          m_ovf [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_seq_unit #(.ADDR_W(32), .RESET_PC(32'h3000), .RAS_DEPTH(4), .DELAY_SLOT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump), .jal(jal), .jr(jr),
    .jr_ra(jr_ra), .beq(beq), .bne(bne), .bgt(bgt), .blt(blt), .zero(zero),
    .positive(positive), .negative(negative), .imm26(imm26), .rs_val(rs_val),
    .pc(pc_o[0]), .pc_plus4(pc_plus4_o[0]), .link_addr(link_o[0]),
    .redirect(redirect_o[0]), .ras_mismatch(mism_o[0]),
    .ras_overflow(ovf_o[0]), .ras_empty(empty_o[0]));

  pc_seq_unit #(.ADDR_W(32), .RESET_PC(32'h3000), .RAS_DEPTH(4), .DELAY_SLOT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump), .jal(jal), .jr(jr),
    .jr_ra(jr_ra), .beq(beq), .bne(bne), .bgt(bgt), .blt(blt), .zero(zero),
    .positive(positive), .negative(negative), .imm26(imm26), .rs_val(rs_val),
    .pc(pc_o[1]), .pc_plus4(pc_plus4_o[1]), .link_addr(link_o[1]),
    .redirect(redirect_o[1]), .ras_mismatch(mism_o[1]),
    .ras_overflow(ovf_o[1]), .ras_empty(empty_o[1]));

  function automatic int rasSize(input int k);
    return (k == 0) ? ras0.size() : ras1.size();
  endfunction

  function automatic logic [31:0] topOf(input int k);
    if (rasSize(k) == 0) return 32'h0;
    return (k == 0) ? ras0[ras0.size()-1] : ras1[ras1.size()-1];
  endfunction

  // A full stack discards its oldest entry to make room.
  task automatic rasPush(input int k, input logic [31:0] v, output bit dropped);
    dropped = 1'b0;
    if (k == 0) begin
      ras0.push_back(v);
      if (ras0.size() > 4) begin void'(ras0.pop_front()); dropped = 1'b1; end
    end else begin
      ras1.push_back(v);
      if (ras1.size() > 4) begin void'(ras1.pop_front()); dropped = 1'b1; end
    end
  endtask

  task automatic rasPop(input int k, output logic [31:0] v);
    v = (k == 0) ? ras0.pop_back() : ras1.pop_back();
  endtask

  // Expected outputs for this cycle, then the architectural state after the edge.
  task automatic stepModel(input int k);
    exp_t        e;
    logic [31:0] p4, tgt, rsa, popped;
    int          off;
    bit          in_slot, tk, dropped;
    if (!rst_n) begin
      m_pc[k] = 32'h3000; m_pend[k] = 32'h0; m_slot[k] = 0; m_mism[k] = 0; m_ovf[k] = 0;
      if (k == 0) ras0.delete(); else ras1.delete();
      return;
    end
    p4         = m_pc[k] + 32'd4;
    in_slot    = (k == 1) && m_slot[k];
    tk         = jr || jump || (beq && zero) || (bne && !zero) || (bgt && positive) || (blt && negative);
    e.pc       = m_pc[k];
    e.pc_plus4 = p4;
    e.link     = (k == 1) ? m_pc[k] + 32'd8 : p4;
    e.redirect = tk && !in_slot;
    e.mism     = m_mism[k];
    e.ovf      = m_ovf[k];
    e.empty    = (rasSize(k) == 0);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    if (stall) begin m_mism[k] = 0; return; end
    if (in_slot) begin m_pc[k] = m_pend[k]; m_slot[k] = 0; m_mism[k] = 0; return; end
    rsa = rs_val & 32'hFFFF_FFFC;
    off = 32'($signed(imm26[15:0]));
    if (jr)        tgt = rsa;
    else if (jump) tgt = (p4 & 32'hF000_0000) | (32'(imm26) * 4);
    else           tgt = p4 + 32'(off * 4);
    m_mism[k] = 0;
    if (jr_ra) begin
      if (rasSize(k) == 0) m_mism[k] = 1;
      else begin rasPop(k, popped); m_mism[k] = (popped != rsa); end
    end
    if (jal && !jr) begin
      rasPush(k, e.link, dropped);
      if (dropped) m_ovf[k] = 1;
    end
    if (tk && k == 1) begin m_pend[k] = tgt; m_pc[k] = p4; m_slot[k] = 1; end
    else if (tk)      m_pc[k] = tgt;
    else              m_pc[k] = p4;
  endtask

  // op: 0 none, 1 beq, 2 bne, 3 bgt, 4 blt, 5 j, 6 jal, 7 jr, 8 jr $ra, 9 jal+jr
  task automatic applyStimulus(input bit rst, input bit st, input int op, input bit z,
                               input bit p, input bit n, input logic [25:0] imm,
                               input logic [31:0] rs);
    @(negedge clk);
    rst_n    = ~rst;
    stall    = st;
    beq      = (op == 1);
    bne      = (op == 2);
    bgt      = (op == 3);
    blt      = (op == 4);
    jump     = (op == 5) || (op == 6) || (op == 9);
    jal      = (op == 6) || (op == 9);
    jr       = (op == 7) || (op == 8) || (op == 9);
    jr_ra    = (op == 8);
    zero     = z;
    positive = p;
    negative = n;
    imm26    = imm;
    rs_val   = rs;
    stepModel(0);
    stepModel(1);
  endtask

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL dut%0d %s: got %h expected %h at %0t", k, name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input int k, input exp_t e);
    chk(k, "pc",           pc_o[k],              e.pc);
    chk(k, "pc_plus4",     pc_plus4_o[k],        e.pc_plus4);
    chk(k, "link_addr",    link_o[k],            e.link);
    chk(k, "redirect",     32'(redirect_o[k]),   32'(e.redirect));
    chk(k, "ras_mismatch", 32'(mism_o[k]),       32'(e.mism));
    chk(k, "ras_overflow", 32'(ovf_o[k]),        32'(e.ovf));
    chk(k, "ras_empty",    32'(empty_o[k]),      32'(e.empty));
  endtask

  // Monitor: every cycle, mid-low-phase, each instance presents one response.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q0.size() > 0) checkOutput(0, q0.pop_front());
      if (q1.size() > 0) checkOutput(1, q1.pop_front());
    end
  end

  initial begin
    int op;
    logic [31:0] rs;
    {rst_n, stall, jump, jal, jr, jr_ra, beq, bne, bgt, blt} = '0;
    {zero, positive, negative} = '0;
    imm26  = '0;
    rs_val = '0;
    for (int ph = 0; ph < 2; ph++) begin
      $display("[TB] phase %0d: RAS targets follow the DELAY_SLOT=%0d model", ph, ph);
      repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      // Backward branch from 0x3010, taken then not taken.
      applyStimulus(0, 0, 7, 0, 0, 0, 26'h0, 32'h3010);
      applyStimulus(0, 0, 1, 1, 0, 0, 26'hFFFE, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      applyStimulus(0, 0, 7, 0, 0, 0, 26'h0, 32'h3010);
      applyStimulus(0, 0, 1, 0, 0, 0, 26'hFFFE, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      // Jump with a bne in the slot, then a stall held through the slot.
      applyStimulus(1, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      applyStimulus(0, 0, 5, 0, 0, 0, 26'h400, 32'h0);
      applyStimulus(0, 0, 2, 0, 0, 0, 26'h10, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      applyStimulus(1, 1, 0, 0, 0, 0, 26'h0, 32'h0);
      applyStimulus(0, 0, 6, 0, 0, 0, 26'h400, 32'h0);
      repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 26'h0, 32'h0);
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      // RAS round trip: matching then mismatching return.
      applyStimulus(1, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      applyStimulus(0, 0, 6, 0, 0, 0, 26'hC00, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      applyStimulus(0, 0, 8, 0, 0, 0, 26'h0, topOf(ph));
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      applyStimulus(0, 0, 6, 0, 0, 0, 26'hC00, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      applyStimulus(0, 0, 8, 0, 0, 0, 26'h0, topOf(ph) + 32'd4);
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      // Overflow with five calls, then five returns, the last from an empty stack.
      applyStimulus(1, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      for (int i = 0; i < 5; i++) begin
        applyStimulus(0, 0, 6, 0, 0, 0, 26'hC00, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      end
      for (int i = 0; i < 5; i++) begin
        applyStimulus(0, 0, 8, 0, 0, 0, 26'h0, topOf(ph));
        applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      // Sequential wrap past the top of the address space.
      applyStimulus(0, 0, 7, 0, 0, 0, 26'h0, 32'hFFFF_FFFC);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 26'h0, 32'h0);
      // Random traffic; occasional reset, sometimes together with stall.
      for (int i = 0; i < 400; i++) begin
        op = int'($urandom_range(0, 9));
        rs = $urandom;
        if (op == 8 && $urandom_range(0, 3) != 0) rs = topOf(ph);
        applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0, op,
                      1'($urandom), 1'($urandom), 1'($urandom), 26'($urandom), rs);
      end
    end
    repeat (3) @(negedge clk);
    #4;
    n_checks++;
    if (q0.size() + q1.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Registered program-counter unit for the single-cycle MIPS core and its pipelined successor. It owns the PC register and computes the next fetch address from sequential increment, beq/bne/bgt/blt branches, j/jal, and jr. Address width is parametrised, an optional branch-delay-slot mode is available, and a small return-address stack (RAS) cross-checks jr $ra. It sits between the main control/ALU flags and instruction memory.

## Interface
- ADDR_W, 32: byte-address width; legal range 28..64.
- RESET_PC, 32'h0000_3000: PC value loaded on reset (ADDR_W bits, word aligned).
- RAS_DEPTH, 4: return-address-stack entries; power of two, 2..16.
- DELAY_SLOT, 0: 1 = MIPS branch-delay-slot semantics; 0 = immediate redirect.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  1  hold the PC and all internal state this cycle.
- jump, jal, jr, jr_ra  in  1 each  decoded control. jal implies jump. jr_ra means jr with rs = $31 and implies jr.
- beq, bne, bgt, blt  in  1 each  branch controls from main control.
- zero, positive, negative  in  1 each  ALU flags.
- imm26  in  26  instruction[25:0]. Branches use bits [15:0].
- rs_val  in  ADDR_W  register value used as the jr target.
- pc  out  ADDR_W  current fetch address.
- pc_plus4  out  ADDR_W  pc + 4.
- link_addr  out  ADDR_W  jal write-back value: pc+4 when DELAY_SLOT=0, pc+8 when DELAY_SLOT=1.
- redirect  out  1  combinational; this cycle's instruction is a taken control transfer.
- ras_mismatch  out  1  registered one-cycle pulse.
- ras_overflow  out  1  sticky until reset.
- ras_empty  out  1  RAS holds no entries.

## Operation
- **Taken condition.** taken = jr | jump | (beq&zero) | (bne&~zero) | (bgt&positive) | (blt&negative). redirect = taken, except it is forced to 0 in state SLOT.
- **Target priority.** jr wins over jump/jal, and jump/jal win over branches.
  - jr target: rs_val with bits [1:0] forced to 0.
  - jump target: {pc_plus4[ADDR_W-1:28], imm26, 2'b00}.
  - branch target: pc_plus4 + (sext(imm26[15:0]) << 2).
- **Arithmetic.** All additions are modulo 2^ADDR_W. pc = all-ones-minus-3 increments to 0 with no flag.
- **DELAY_SLOT=0.** The next pc is target if taken, else pc_plus4.
- **DELAY_SLOT=1 state machine.**
  - SEQ: on taken, latch target into pend_pc, next pc = pc_plus4, go to SLOT.
  - SLOT: next pc = pend_pc, return to SEQ. All control inputs are ignored; a control transfer in the delay slot is architecturally illegal and produces no push or pop.
- **RAS push.** A jal that is accepted (not stalled, not ignored in SLOT) pushes link_addr.
  - When full, the push overwrites the oldest entry (circular pointer), the depth stays RAS_DEPTH, and ras_overflow is set.
- **RAS pop.** An accepted jr_ra pops.
  - ras_mismatch pulses in the next cycle if the popped value differs from rs_val & ~3.
  - A pop while empty also pulses ras_mismatch and leaves the pointer unchanged.
- **jal and jr together.** jr wins; no push occurs.
- **Stall.** pc, state, pend_pc and the RAS are all frozen. Outputs stay combinationally valid. ras_mismatch is cleared in a stalled cycle.

## Timing
- pc, pc_plus4 and link_addr become valid after reset with no latency; pc is a register output.
- Inputs are sampled in the same cycle. The new pc appears the cycle after the edge on which the transfer is accepted.
- DELAY_SLOT=1: the target is fetched two cycles after the branch.
- Reset values:
  - pc = RESET_PC, state = SEQ, pend_pc = 0.
  - RAS empty: ras_empty=1, ras_overflow=0, ras_mismatch=0.
- Reset asserted mid-SLOT abandons pend_pc.
- Reset has priority over stall.

## Structure
- Shared package pc_pkg holds:
  - the state enum (SEQ, SLOT);
  - a function computing the target with the priority above;
  - localparam RAS_PTR_W = $clog2(RAS_DEPTH).
- Sub-module ras_stack (DEPTH, WIDTH):
  - inputs push, pop, din;
  - outputs top, empty, overflow;
  - circular storage with a count register.
- The top level holds the PC register, the SLOT FSM and the mismatch register.

## Test plan
- **Reset and increment.** Reset with ADDR_W=32, then release for 3 cycles -> pc 0x3000, 0x3004, 0x3008. ras_empty=1.
- **Backward branch.** pc=0x3010, beq=1, zero=1, imm26[15:0]=16'hFFFE -> redirect=1 and next pc = 0x300C. With zero=0 -> next pc = 0x3014.
- **Delay slot.** DELAY_SLOT=1, pc=0x3000, j with imm26=0x0000400 -> pc sequence 0x3004, then 0x1000. A bne asserted at 0x3004 is ignored.
- **RAS round trip.** jal at 0x3000 -> link_addr 0x3004, push. Later jr_ra with rs_val=0x3004 -> pc 0x3004, no ras_mismatch. Repeat with rs_val=0x3008 -> one-cycle ras_mismatch.
- **RAS limits.** RAS_DEPTH=4 and five jal -> ras_overflow=1. Five jr_ra -> the fifth pops empty and pulses ras_mismatch.
- **Stall and wrap.** stall held 3 cycles during SLOT -> pc, state and RAS unchanged. pc=0xFFFF_FFFC sequential -> pc 0x0000_0000.
